bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 4, legal range 2..8; number of master ports.
REQ-002 SHALL have parameter IDX_W, default $clog2(N_MASTERS); width of grant index.
REQ-003 clk  input  Clock_t  system clock bundle; only clk.base clocks the block.
REQ-004 clk.rst  input  1  reset, asynchronous, active-high.
REQ-005 m_address  input  N_MASTERS x 32  per-master address.
REQ-006 m_read, m_write  input  N_MASTERS x 1  per-master request strobes.
REQ-007 m_data_wr  input  N_MASTERS x 32  per-master write data.
REQ-008 m_mask  input  N_MASTERS x 4  per-master byte mask.
REQ-009 m_stall  output  N_MASTERS x 1  per-master stall.
REQ-010 m_data_rd, m_data_rd_2  output  32 each  read data, broadcast to all masters.
REQ-011 s_address, s_data_wr  output  32 each  to slave.
REQ-012 s_read, s_write  output  1 each  to slave.
REQ-013 s_mask  output  4  to slave.
REQ-014 s_stall  input  1  slave stall.
REQ-015 s_data_rd, s_data_rd_2  input  32 each  slave read data.
REQ-016 grant_valid  output  1  BUSY indicator; grant_idx  output  IDX_W  current grant.

Function
REQ-017 Request of master i SHALL be req[i] = m_read[i] | m_write[i]; masters hold request until they see m_stall[i]=0.
REQ-018 FSM SHALL have states IDLE and BUSY.
REQ-019 IDLE: if any req, SHALL register grant = first requesting index searching last_grant+1, +2, ... modulo N_MASTERS, and enter BUSY next cycle; otherwise stay IDLE.
REQ-020 Arbitration latency SHALL be exactly one cycle: request first seen in IDLE cycle t reaches slave in cycle t+1.
REQ-021 BUSY with grant g: s_address/s_read/s_write/s_data_wr/s_mask SHALL equal m_*[g] combinationally.
REQ-022 BUSY: m_stall[g] SHALL equal s_stall; m_stall[i] for i != g SHALL equal req[i].
REQ-023 IDLE: m_stall[i] SHALL equal req[i] for all i; s_read=s_write=0, s_address=s_data_wr=0, s_mask=0.
REQ-024 BUSY cycle with req[g]=1 and s_stall=0 SHALL complete: last_grant <= g, state <= IDLE.
REQ-025 BUSY cycle with req[g]=0 (master withdrew) SHALL abort to IDLE without updating last_grant; slave sees no strobe that cycle.
REQ-026 m_data_rd/m_data_rd_2 SHALL equal s_data_rd/s_data_rd_2 unconditionally.
REQ-027 Grant SHALL NOT change while in BUSY regardless of other requests.
REQ-028 Back-to-back: minimum two cycles per transaction (one IDLE, >=1 BUSY); round-robin guarantees each requester is served within N_MASTERS transactions.
REQ-029 grant_valid SHALL be 1 exactly in BUSY; grant_idx SHALL show registered grant (0 in IDLE).

Reset
REQ-030 On clk.rst=1, asynchronously: state=IDLE, grant=0, last_grant=N_MASTERS-1 (so master 0 wins first contention).
REQ-031 During reset, outputs SHALL be: s_* strobes/data/mask = 0, grant_valid=0, grant_idx=0, m_stall[i]=req[i].
REQ-032 Reset asserted mid-transaction SHALL drop s_read/s_write immediately; no completion recorded.

Structure
REQ-033 N_MASTERS default, mask width and round-robin index type SHALL live in the shared defs package beside Bus_if/ByteMask_t.
REQ-034 Round-robin priority search SHALL be a sub-module rr_pick (inputs req, last_grant; outputs idx, found), purely combinational.
REQ-035 Top SHALL expose a Bus_if.slave-per-master wrapper variant later; this block uses flat ports only.

Verification
REQ-036 Single master 2 read, s_stall=0 -> IDLE one cycle, BUSY one cycle, s_read=1 with m_address[2], m_stall[2]=1 then 0.
REQ-037 After reset, masters 0 and 3 request together -> master 0 granted first, master 3 granted next, m_stall[3]=1 throughout first transaction.
REQ-038 All 4 masters request continuously, s_stall=0 -> grant sequence 0,1,2,3,0 with every other cycle IDLE.
REQ-039 Master 1 granted, s_stall=1 for 3 cycles -> s_* stable, grant_idx=1 for 4 BUSY cycles, completes when s_stall=0.
REQ-040 Master 2 drops m_write mid-BUSY -> abort to IDLE, last_grant unchanged, next winner by prior pointer.
REQ-041 clk.rst asserted in BUSY with s_stall=1 -> s_write=0 same cycle, grant_valid=0, master 0 wins after release.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: bus widths, the clock
// bundle, the FSM state encoding and the round-robin index helpers.
package bus_arbiter_pkg;

  localparam int N_MASTERS_DEF = 4;
  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int MASK_W        = 4;
  localparam int RR_IDX_W      = $clog2(N_MASTERS_DEF);

  typedef logic [MASK_W-1:0]   byte_mask_t;
  typedef logic [RR_IDX_W-1:0] rr_idx_t;

  // Only base clocks the arbiter; rst is the asynchronous active-high reset.
  typedef struct packed {
    logic base;
    logic rst;
  } clock_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Candidate visited at step k of a round-robin search that starts after last.
  function automatic int rr_next(input int last, input int k, input int n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search: returns the first requester found at
// last_grant+1, last_grant+2, ... modulo N, and whether any requester exists.
module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N     = N_MASTERS_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every signal written here gets a default first, so no path through
  // the loop can leave one unassigned and infer a latch.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'(rr_next(int'(last_grant_i), k, N));
      if (!found_o && req_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// N-master to single-slave bus arbiter: one IDLE arbitration cycle, then the
// winning master is connected straight through to the slave until it completes.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int IDX_W     = $clog2(N_MASTERS)
) (
  input  clock_t                               clk_i,
  input  logic       [N_MASTERS-1:0][ADDR_W-1:0] m_address_i,
  input  logic       [N_MASTERS-1:0]             m_read_i,
  input  logic       [N_MASTERS-1:0]             m_write_i,
  input  logic       [N_MASTERS-1:0][DATA_W-1:0] m_data_wr_i,
  input  byte_mask_t [N_MASTERS-1:0]             m_mask_i,
  output logic       [N_MASTERS-1:0]             m_stall_o,
  output logic       [DATA_W-1:0]                m_data_rd_o,
  output logic       [DATA_W-1:0]                m_data_rd_2_o,
  output logic       [ADDR_W-1:0]                s_address_o,
  output logic       [DATA_W-1:0]                s_data_wr_o,
  output logic                                   s_read_o,
  output logic                                   s_write_o,
  output byte_mask_t                             s_mask_o,
  input  logic                                   s_stall_i,
  input  logic       [DATA_W-1:0]                s_data_rd_i,
  input  logic       [DATA_W-1:0]                s_data_rd_2_i,
  output logic                                   grant_valid_o,
  output logic       [IDX_W-1:0]                 grant_idx_o
);

  logic clk;
  logic rst;
  assign clk = clk_i.base;
  assign rst = clk_i.rst;

  logic [N_MASTERS-1:0] req;
  assign req = m_read_i | m_write_i;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .idx_o        (pick_idx),
    .found_o      (pick_found)
  );

  // Read data is broadcast; only the granted master acts on it.
  assign m_data_rd_o   = s_data_rd_i;
  assign m_data_rd_2_o = s_data_rd_2_i;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!req[grant_q]) begin
          // Master withdrew: abort without moving the round-robin pointer.
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (!s_stall_i) begin
          last_grant_d = grant_q;
          grant_d      = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A withdrawn master has both strobes low, so passing its signals through
  // during the abort cycle presents no strobe to the slave.
  always_comb begin
    m_stall_o     = req;
    s_address_o   = '0;
    s_data_wr_o   = '0;
    s_read_o      = 1'b0;
    s_write_o     = 1'b0;
    s_mask_o      = '0;
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    if (state_q == ST_BUSY) begin
      m_stall_o[grant_q] = s_stall_i;
      s_address_o        = m_address_i[grant_q];
      s_data_wr_o        = m_data_wr_i[grant_q];
      s_read_o           = m_read_i[grant_q];
      s_write_o          = m_write_i[grant_q];
      s_mask_o           = m_mask_i[grant_q];
      grant_valid_o      = 1'b1;
      grant_idx_o        = grant_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_MASTERS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
